// File: rtl/calc_alu_sequencer_if.sv
// Bus bundle between the operand/opcode source, the sequencer, an external
// combinational ALU and the result consumer.
//
// Handshake semantics (both channels): a transfer happens on the rising clk
// edge where valid && ready are both high. The in channel is driven by the
// source (in_valid/in_data) and accepted by the sequencer (in_ready). The
// result channel is driven by the sequencer (res_valid/res_*) and accepted by
// the consumer (res_ready). The sender holds its payload stable until the
// transfer happens. in_ready is a pure function of the FSM state, and
// res_valid never drops without a handshake, abort or reset.
interface calc_alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
);
    // Operand/opcode input channel
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    // ALU side
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        alu_flag;
    // Result channel
    logic [DATA_W-1:0] res_data;
    logic [3:0]        res_flag;
    logic              res_err;
    logic              res_valid;
    logic              res_ready;
    logic [7:0]        op_cnt;
    // FSM state for observation: 0 GET_A, 1 GET_B, 2 GET_OP, 3 EXEC, 4 RESP
    logic [2:0]        dbg_state;

    // Sequencer side
    modport slave (
        input  in_data, in_valid, abort, alu_out, alu_flag, res_ready,
        output in_ready, alu_a, alu_b, alu_sel,
        output res_data, res_flag, res_err, res_valid, op_cnt, dbg_state
    );

    // Environment side (source, ALU, consumer)
    modport master (
        output in_data, in_valid, abort, alu_out, alu_flag, res_ready,
        input  in_ready, alu_a, alu_b, alu_sel,
        input  res_data, res_flag, res_err, res_valid, op_cnt, dbg_state
    );
endinterface

// File: rtl/calc_alu_sequencer.sv
// Collects operand A, operand B and an opcode beat, presents them to an
// external combinational ALU, registers the ALU result one cycle later and
// holds it until the consumer takes it. abort cancels the current operation
// at any point; op_cnt counts retired results.
module calc_alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    calc_alu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_GET_A  = 3'd0,
        S_GET_B  = 3'd1,
        S_GET_OP = 3'd2,
        S_EXEC   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_res_data;
    logic [3:0]        r_res_flag;
    logic              r_res_err;
    logic [7:0]        r_op_cnt;

    logic              w_in_ready;
    logic              w_res_valid;
    logic              w_beat;
    logic              w_retire;

    // A beat is taken only when the sequencer is listening; abort suppresses
    // both beat loads and result retirement.
    assign w_beat   = bus.in_valid && w_in_ready && !bus.abort;
    assign w_retire = w_res_valid && bus.res_ready && !bus.abort;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_GET_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_next_state = r_state;
        if (bus.abort) begin
            w_next_state = S_GET_A;
        end else begin
            case (r_state)
                S_GET_A:  if (w_beat) w_next_state = S_GET_B;
                S_GET_B:  if (w_beat) w_next_state = S_GET_OP;
                S_GET_OP: if (w_beat) w_next_state = S_EXEC;
                S_EXEC:   w_next_state = S_RESP;
                S_RESP:   if (bus.res_ready) w_next_state = S_GET_A;
                default:  w_next_state = S_GET_A;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            S_GET_A, S_GET_B, S_GET_OP: w_in_ready  = 1'b1;
            S_RESP:                     w_res_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_res_valid = 1'b0;
            end
        endcase
    end

    // Operand/opcode capture and result registration; operands survive abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sel      <= '0;
            r_res_data <= '0;
            r_res_flag <= '0;
            r_res_err  <= 1'b0;
        end else if (!bus.abort) begin
            case (r_state)
                S_GET_A:  if (w_beat) r_a   <= bus.in_data;
                S_GET_B:  if (w_beat) r_b   <= bus.in_data;
                S_GET_OP: if (w_beat) r_sel <= bus.in_data[SEL_W-1:0];
                S_EXEC: begin
                    r_res_data <= bus.alu_out;
                    r_res_flag <= bus.alu_flag;
                    r_res_err  <= (r_sel > SEL_W'(11));
                end
                default: ;
            endcase
        end
    end

    // Retired-result counter, wraps modulo 256
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_cnt <= 8'd0;
        end else if (w_retire) begin
            r_op_cnt <= r_op_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.alu_sel   = r_sel;
    assign bus.res_data  = r_res_data;
    assign bus.res_flag  = r_res_flag;
    assign bus.res_err   = r_res_err;
    assign bus.op_cnt    = r_op_cnt;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed bench for calc_alu_sequencer with a small reference ALU attached.
module tb_calc_alu_sequencer;

    localparam logic [2:0] S_GET_A  = 3'd0;
    localparam logic [2:0] S_GET_B  = 3'd1;
    localparam logic [2:0] S_GET_OP = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [7:0] exp_cnt;

    calc_alu_sequencer_if #(.DATA_W(8), .SEL_W(4)) bus ();

    calc_alu_sequencer #(.DATA_W(8), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference ALU: 0 add, 1 sub, 2 inc, 3 dec, 4 or, 5 xor, 6 and, 7 not,
    // 8 shl, 9 shr, A rol, B ror, otherwise nor.
    // Flags: {zero, msb, a[0], b[0]}.
    logic [7:0] alu_res;
    always_comb begin
        case (bus.alu_sel)
            4'h0: alu_res = bus.alu_a + bus.alu_b;
            4'h1: alu_res = bus.alu_a - bus.alu_b;
            4'h2: alu_res = bus.alu_a + 8'd1;
            4'h3: alu_res = bus.alu_a - 8'd1;
            4'h4: alu_res = bus.alu_a | bus.alu_b;
            4'h5: alu_res = bus.alu_a ^ bus.alu_b;
            4'h6: alu_res = bus.alu_a & bus.alu_b;
            4'h7: alu_res = ~bus.alu_a;
            4'h8: alu_res = {bus.alu_a[6:0], 1'b0};
            4'h9: alu_res = {1'b0, bus.alu_a[7:1]};
            4'hA: alu_res = {bus.alu_a[6:0], bus.alu_a[7]};
            4'hB: alu_res = {bus.alu_a[0], bus.alu_a[7:1]};
            default: alu_res = ~(bus.alu_a | bus.alu_b);
        endcase
        bus.alu_out  = alu_res;
        bus.alu_flag = {(alu_res == 8'h00), alu_res[7], bus.alu_a[0], bus.alu_b[0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},     bus.dbg_state, S_GET_A);
        chk({tag, "_alu_a"},     bus.alu_a, 8'h00);
        chk({tag, "_alu_b"},     bus.alu_b, 8'h00);
        chk({tag, "_alu_sel"},   bus.alu_sel, 4'h0);
        chk({tag, "_res_data"},  bus.res_data, 8'h00);
        chk({tag, "_res_flag"},  bus.res_flag, 4'h0);
        chk({tag, "_res_err"},   bus.res_err, 1'b0);
        chk({tag, "_res_valid"}, bus.res_valid, 1'b0);
        chk({tag, "_op_cnt"},    bus.op_cnt, 8'h00);
    endtask

    // driver tasks
    task automatic drive_beat(input logic [7:0] data);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic send_beat(input string tag, input logic [7:0] data);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        drive_beat(data);
    endtask

    // Full operation with immediate consumer; checks EXEC, RESP and retirement.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [7:0] exp_d,
                         input logic [3:0] exp_f, input logic exp_e);
        send_beat({tag, "_a"}, a);
        send_beat({tag, "_b"}, b);
        send_beat({tag, "_op"}, op);
        chk({tag, "_exec_state"},    bus.dbg_state, S_EXEC);
        chk({tag, "_exec_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_exec_res_valid"}, bus.res_valid, 1'b0);
        tick();
        chk({tag, "_resp_valid"},    bus.res_valid, 1'b1);
        chk({tag, "_resp_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_res_data"},      bus.res_data, exp_d);
        chk({tag, "_res_flag"},      bus.res_flag, exp_f);
        chk({tag, "_res_err"},       bus.res_err, exp_e);
        chk({tag, "_alu_a"},         bus.alu_a, a);
        chk({tag, "_alu_b"},         bus.alu_b, b);
        chk({tag, "_alu_sel"},       bus.alu_sel, op[3:0]);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, "_op_cnt"},        bus.op_cnt, exp_cnt);
        chk({tag, "_done_state"},    bus.dbg_state, S_GET_A);
        chk({tag, "_done_valid"},    bus.res_valid, 1'b0);
    endtask

    // directed sequence
    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_cnt       = 8'h00;
        rst           = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b0;

        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk("reset_in_ready", bus.in_ready, 1'b1);
        chk("reset_state_idle", bus.dbg_state, S_GET_A);

        // add / sub / and
        do_op("add",  8'h2B, 8'h04, 8'h00, 8'h2F, 4'h2, 1'b0);
        do_op("sub",  8'h2B, 8'h04, 8'h01, 8'h27, 4'h2, 1'b0);
        do_op("and",  8'h2B, 8'h06, 8'h06, 8'h02, 4'h2, 1'b0);
        // opcode range boundary
        do_op("sel_c", 8'h2B, 8'h04, 8'h0C, 8'hD0, 4'h6, 1'b1);
        do_op("sel_b", 8'h2B, 8'h04, 8'h0B, 8'h95, 4'h6, 1'b0);
        // upper opcode bits are not part of the select
        do_op("sel_hi", 8'h01, 8'h10, 8'hF5, 8'h11, 4'h2, 1'b0);

        // consumer stall for 5 cycles, junk beats offered meanwhile
        send_beat("stall_a", 8'h11);
        send_beat("stall_b", 8'h20);
        send_beat("stall_op", 8'h04);
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", bus.res_valid, 1'b1);
            chk("stall_data",  bus.res_data, 8'h31);
            chk("stall_flag",  bus.res_flag, 4'h2);
            chk("stall_in_ready", bus.in_ready, 1'b0);
            chk("stall_cnt",   bus.op_cnt, exp_cnt);
            if (i < 4) tick();
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("stall_retire_cnt", bus.op_cnt, exp_cnt);
        chk("stall_retire_state", bus.dbg_state, S_GET_A);
        chk("stall_ignored_a", bus.alu_a, 8'h11);

        // abort after operand A
        send_beat("abort_a", 8'h55);
        chk("abort_a_in_b", bus.dbg_state, S_GET_B);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_a_state", bus.dbg_state, S_GET_A);
        chk("abort_a_cnt",   bus.op_cnt, exp_cnt);
        chk("abort_a_keep",  bus.alu_a, 8'h55);

        // abort coinciding with an opcode beat: opcode not loaded
        send_beat("abort_op_a", 8'h01);
        send_beat("abort_op_b", 8'h02);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h03;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_op_state", bus.dbg_state, S_GET_A);
        chk("abort_op_sel",   bus.alu_sel, 4'h4);
        chk("abort_op_b",     bus.alu_b, 8'h02);

        // abort in RESP with a simultaneous handshake
        send_beat("abort_resp_a", 8'h01);
        send_beat("abort_resp_b", 8'h02);
        send_beat("abort_resp_op", 8'h00);
        tick();
        chk("abort_resp_valid_before", bus.res_valid, 1'b1);
        chk("abort_resp_data", bus.res_data, 8'h03);
        bus.abort     = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.res_ready = 1'b0;
        chk("abort_resp_state", bus.dbg_state, S_GET_A);
        chk("abort_resp_valid", bus.res_valid, 1'b0);
        chk("abort_resp_cnt",   bus.op_cnt, exp_cnt);
        chk("abort_resp_keep_a", bus.alu_a, 8'h01);

        // asynchronous reset mid GET_B
        send_beat("rst_mid_a", 8'h77);
        chk("rst_mid_in_b", bus.dbg_state, S_GET_B);
        rst = 1'b1;
        #2;
        chk_reset("rst_mid");
        exp_cnt = 8'h00;
        #1;
        rst = 1'b0;
        tick();
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);

        // counter wrap after 256 retirements
        bus.res_ready = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            drive_beat(i[7:0]);
            drive_beat(8'h01);
            drive_beat(8'h00);
            tick();
            tick();
            if (i == 255) chk("wrap_ff", bus.op_cnt, 8'hFF);
        end
        bus.res_ready = 1'b0;
        chk("wrap_00", bus.op_cnt, 8'h00);
        chk("wrap_state", bus.dbg_state, S_GET_A);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_alu_sequencer.md
CALC_ALU_SEQUENCER -- requirements
Module: calc_alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 SHALL have parameter SEL_W, default 4, ALU operation-select width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_data, input, 8, operand or opcode beat (opcode in bits [3:0]).
REQ-006 SHALL have port in_valid, input, 1, in_data valid.
REQ-007 SHALL have port in_ready, output, 1, sequencer accepts a beat.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current operation.
REQ-009 SHALL have port alu_a, output, 8, operand A to the ALU.
REQ-010 SHALL have port alu_b, output, 8, operand B to the ALU.
REQ-011 SHALL have port alu_sel, output, 4, operation select to the ALU.
REQ-012 SHALL have port alu_out, input, 8, combinational ALU result.
REQ-013 SHALL have port alu_flag, input, 4, combinational ALU flags (opaque, passed through).
REQ-014 SHALL have port res_data, output, 8, registered result.
REQ-015 SHALL have port res_flag, output, 4, registered flags.
REQ-016 SHALL have port res_err, output, 1, opcode was outside 0x0..0xB.
REQ-017 SHALL have port res_valid, output, 1, result available.
REQ-018 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-019 SHALL have port op_cnt, output, 8, count of completed result handshakes.

Function
REQ-020 SHALL implement FSM states GET_A, GET_B, GET_OP, EXEC, RESP; reset state GET_A.
REQ-021 SHALL assert in_ready combinationally in GET_A, GET_B, GET_OP only; beat accepted on edge where in_valid && in_ready.
REQ-022 SHALL, on accepted beat, load a_q (GET_A->GET_B), b_q (GET_B->GET_OP), sel_q = in_data[3:0] (GET_OP->EXEC); no transition without a beat.
REQ-023 SHALL drive alu_a=a_q, alu_b=b_q, alu_sel=sel_q directly from registers at all times.
REQ-024 SHALL spend exactly one cycle in EXEC, then on the next edge capture alu_out->res_data, alu_flag->res_flag, (sel_q > 0xB)->res_err, and enter RESP.
REQ-025 SHALL assert res_valid only in RESP; res_valid rises one edge after the opcode-beat edge.
REQ-026 SHALL hold res_data, res_flag, res_err stable while res_valid && !res_ready.
REQ-027 SHALL, on res_valid && res_ready, go to GET_A and increment op_cnt modulo 256 (0xFF->0x00).
REQ-028 SHALL keep in_ready low in EXEC and RESP; no overlap of a new operation with an unretired result.
REQ-029 SHALL treat abort as highest priority: next edge -> GET_A, res_valid=0, op_cnt unchanged, a_q/b_q/sel_q retained; abort with a simultaneous handshake does not count.
REQ-030 SHALL ignore in_data/in_valid while in_ready is low.

Reset
REQ-031 SHALL, while rst=1 (asynchronously), force state GET_A, a_q=b_q=0x00, sel_q=0x0, res_data=0x00, res_flag=0x0, res_err=0, res_valid=0, op_cnt=0x00; in_ready=1 after release.
REQ-032 SHALL discard any partially loaded or pending operation when rst asserts mid-sequence, including in RESP.

Verification
REQ-033 Beats 0x2B, 0x04, 0x00 with res_ready=1, M_ALU attached -> res_valid one edge after op beat, res_data=0x2F, op_cnt=1.
REQ-034 Beats 0x2B, 0x04, 0x01 then 0x2B, 0x06, 0x06 -> results 0x27 then 0x02; in_ready low from op beat until each handshake.
REQ-035 Beats 0x2B, 0x04, 0x0C -> res_err=1, res_data equals alu_out for sel 0xC; beats 0x2B, 0x04, 0x0B -> res_err=0.
REQ-036 res_ready held low 5 cycles in RESP -> res_data/res_flag/res_valid constant for all 5; handshake on 6th edge, op_cnt +1.
REQ-037 abort after A beat, and separately abort during RESP with res_ready=1 -> state GET_A, res_valid=0, op_cnt unchanged; rst asserted mid-GET_B -> all REQ-031 values immediately, without a clock edge.
REQ-038 256 completed operations from reset -> op_cnt wraps to 0x00.
